// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D interface and its SPI master.
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TX1  = 3'd1,
        DEAD = 3'd2,
        TX2  = 3'd3,
        DONE = 3'd4
    } a2d_state_e;

    localparam int SCLK_DIV_W = 5;
    localparam logic [SCLK_DIV_W-1:0] SCLK_PRELOAD = 5'b10111;
    localparam int FRAME_BITS = 16;
    localparam int RES_BITS   = 12;

    // Divider values: last SCLK-low cycle, last SCLK-high cycle, and the
    // cycle before a transfer's final falling-edge point.
    localparam logic [SCLK_DIV_W-1:0] DIV_RISE = 5'b01111;
    localparam logic [SCLK_DIV_W-1:0] DIV_FALL = 5'b11111;
    localparam logic [SCLK_DIV_W-1:0] DIV_LAST = 5'b11110;

    // Command word sent to the ADC: channel number in bits [13:11].
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_intf_spi_mstr16.sv
// 16-bit SPI master: SCLK = clk/32 from a free-running divider, MISO
// sampled on rising SCLK, MOSI shifted on falling SCLK. 'done' strobes
// in the last SS_n-low cycle, i.e. the transfer ends at that clock edge
// and SS_n is high from the next cycle on.
module spi_mstr16
    import a2d_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrt,
    input  logic [FRAME_BITS-1:0] cmd,
    input  logic                  MISO,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rd_data,
    output logic                  SS_n,
    output logic                  SCLK,
    output logic                  MOSI
);

    localparam logic [4:0] SMPL_LAST = 5'(FRAME_BITS);

    logic                  ss_n_q, ss_n_d;
    logic [SCLK_DIV_W-1:0] div_q, div_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [4:0]            smpl_cnt_q, smpl_cnt_d;

    logic active, smpl, shft, last;

    // Strobes decoded from the divider. Shifting is suppressed until the
    // first sample so the MSB is presented for the first rising edge.
    always_comb begin
        active = ~ss_n_q;
        smpl   = active && (div_q == DIV_RISE);
        shft   = active && (div_q == DIV_FALL) && (smpl_cnt_q != 5'd0);
        last   = active && (div_q == DIV_LAST) && (smpl_cnt_q == SMPL_LAST);
    end

    // Next-state for divider, shift registers and slave select.
    always_comb begin
        ss_n_d     = ss_n_q;
        div_d      = div_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        smpl_cnt_d = smpl_cnt_q;
        if (wrt) begin
            ss_n_d     = 1'b0;
            div_d      = SCLK_PRELOAD;
            tx_d       = cmd;
            smpl_cnt_d = 5'd0;
        end else if (active) begin
            div_d = div_q + 5'd1;
            if (smpl) begin
                rx_d       = {rx_q[FRAME_BITS-2:0], MISO};
                smpl_cnt_d = smpl_cnt_q + 5'd1;
            end
            if (shft) begin
                tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
            end
            if (last) begin
                ss_n_d = 1'b1;
            end
        end
    end

    // State registers; reset raises SS_n immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_n_q     <= 1'b1;
            div_q      <= SCLK_PRELOAD;
            tx_q       <= '0;
            rx_q       <= '0;
            smpl_cnt_q <= 5'd0;
        end else begin
            ss_n_q     <= ss_n_d;
            div_q      <= div_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            smpl_cnt_q <= smpl_cnt_d;
        end
    end

    assign done    = last;
    assign rd_data = rx_q;
    assign SS_n    = ss_n_q;
    assign SCLK    = ss_n_q | div_q[SCLK_DIV_W-1];
    assign MOSI    = ~ss_n_q & tx_q[FRAME_BITS-1];

endmodule

// File: rtl/a2d_intf.sv
// A2D converter interface: two back-to-back SPI transfers per conversion
// (channel select, then readback), one dead cycle between them.
// Build option A2D_RES_INVERT_EN: res is the bitwise inverse of the
// received 12 LSBs (reversed potentiometer wiring); timing unchanged.
module a2d_intf
    import a2d_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                strt_cnv,
    input  logic [2:0]          chnnl,
    input  logic                MISO,
    output logic                SS_n,
    output logic                SCLK,
    output logic                MOSI,
    output logic                cnv_cmplt,
    output logic [RES_BITS-1:0] res
);

    a2d_state_e state_q, state_d;
    logic [2:0]          chnl_q, chnl_d;
    logic                cnv_q, cnv_d;
    logic [RES_BITS-1:0] res_q, res_d;

    logic                  wrt;
    logic [FRAME_BITS-1:0] cmd;
    logic                  done;
    logic [FRAME_BITS-1:0] rd_data;
    logic                  unused_rd_hi;

    assign unused_rd_hi = ^rd_data[FRAME_BITS-1:RES_BITS];

    spi_mstr16 u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .cmd     (cmd),
        .MISO    (MISO),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI)
    );

    // Conversion sequencer. DONE's first cycle (cnv_q still low) latches
    // the result and ignores strt_cnv; later DONE cycles accept a new start.
    always_comb begin
        state_d = state_q;
        chnl_d  = chnl_q;
        cnv_d   = cnv_q;
        res_d   = res_q;
        wrt     = 1'b0;
        cmd     = make_frame(chnl_q);
        case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    state_d = TX1;
                    chnl_d  = chnnl;
                    cnv_d   = 1'b0;
                    wrt     = 1'b1;
                    cmd     = make_frame(chnnl);
                end
            end
            TX1: begin
                if (done) state_d = DEAD;
            end
            DEAD: begin
                wrt     = 1'b1;
                state_d = TX2;
            end
            TX2: begin
                if (done) state_d = DONE;
            end
            DONE: begin
                if (!cnv_q) begin
                    cnv_d = 1'b1;
`ifdef A2D_RES_INVERT_EN
                    res_d = ~rd_data[RES_BITS-1:0];
`else
                    res_d = rd_data[RES_BITS-1:0];
`endif
                end else if (strt_cnv) begin
                    state_d = TX1;
                    chnl_d  = chnnl;
                    cnv_d   = 1'b0;
                    wrt     = 1'b1;
                    cmd     = make_frame(chnnl);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            chnl_q  <= 3'd0;
            cnv_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            chnl_q  <= chnl_d;
            cnv_q   <= cnv_d;
            res_q   <= res_d;
        end
    end

    assign cnv_cmplt = cnv_q;
    assign res       = res_q;

endmodule
